// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared widths, flit layout, pack/unpack helpers and err bit indices for the NoC NI.
package noc_pkg;

  localparam int NOC_ADDR_W    = 2;
  localparam int NOC_PAYLOAD_W = 16;
  localparam int NOC_FLIT_W    = 2 * NOC_ADDR_W + NOC_PAYLOAD_W;

  localparam int PAYLOAD_LSB = 0;
  localparam int LOCAL_LSB   = NOC_PAYLOAD_W;
  localparam int CLUSTER_LSB = NOC_PAYLOAD_W + NOC_ADDR_W;

  localparam int ERR_EJ_OVF     = 0;
  localparam int ERR_CREDIT_OVF = 1;

  typedef struct packed {
    logic [NOC_ADDR_W-1:0]    dest_cluster;
    logic [NOC_ADDR_W-1:0]    dest_local;
    logic [NOC_PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic flit_t flit_pack(input logic [NOC_ADDR_W-1:0]    dest_cluster,
                                      input logic [NOC_ADDR_W-1:0]    dest_local,
                                      input logic [NOC_PAYLOAD_W-1:0] payload);
    flit_t f;
    f.dest_cluster = dest_cluster;
    f.dest_local   = dest_local;
    f.payload      = payload;
    return f;
  endfunction

  function automatic logic [NOC_PAYLOAD_W-1:0] flit_payload(input flit_t f);
    return f.payload;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - show-ahead synchronous FIFO; a push while full is taken only alongside a pop.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the show-ahead output is clean out of reset.
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/noc_network_interface.sv
// rtl/noc_network_interface.sv - PE-to-router NI: injection FIFO with credit flow control, ejection FIFO with credit return.
// Optional NOC_NI_STATS_EN adds saturating stat_inj/stat_ej/stat_stall counters.
module noc_network_interface
  import noc_pkg::*;
#(
  parameter int ADDR_W    = NOC_ADDR_W,
  parameter int PAYLOAD_W = NOC_PAYLOAD_W,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CREDITS   = 4,
  localparam int FLIT_W   = 2 * ADDR_W + PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pe_valid,
  output logic                 pe_ready,
  input  logic [ADDR_W-1:0]    pe_dest_cluster,
  input  logic [ADDR_W-1:0]    pe_dest_local,
  input  logic [PAYLOAD_W-1:0] pe_data,
  output logic [FLIT_W-1:0]    inject,
  output logic                 inject_valid,
  input  logic                 ci,
  input  logic [FLIT_W-1:0]    eject,
  input  logic                 eject_valid,
  output logic                 co,
  output logic                 rd_valid,
  input  logic                 rd_en,
  output logic [PAYLOAD_W-1:0] rd_data,
  output logic [PAYLOAD_W-1:0] read,
  output logic [1:0]           err
`ifdef NOC_NI_STATS_EN
  ,
  output logic [15:0]          stat_inj,
  output logic [15:0]          stat_ej,
  output logic [15:0]          stat_stall
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0]        credit_cnt_q, credit_cnt_d;
  logic [FLIT_W-1:0]    inject_q, inject_d;
  logic                 inject_valid_q, inject_valid_d;
  logic                 co_q, co_d;
  logic [PAYLOAD_W-1:0] read_q, read_d;
  logic [1:0]           err_q, err_d;

  logic [FLIT_W-1:0] inj_head, ej_head;
  logic              inj_full, inj_empty, ej_full, ej_empty;
  logic              send, ej_pop, ej_drop;
  logic              unused_ej_hdr;

  assign pe_ready = !inj_full;
  assign send     = !inj_empty && (credit_cnt_q != '0);
  assign ej_pop   = rd_en && !ej_empty;
  assign ej_drop  = eject_valid && ej_full && !ej_pop;

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pe_valid && pe_ready),
    .push_data ({pe_dest_cluster, pe_dest_local, pe_data}),
    .pop       (send),
    .head      (inj_head),
    .full      (inj_full),
    .empty     (inj_empty)
  );

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eject_valid),
    .push_data (eject),
    .pop       (ej_pop),
    .head      (ej_head),
    .full      (ej_full),
    .empty     (ej_empty)
  );

  // The PE only sees payloads; routing fields of ejected flits are not forwarded.
  assign unused_ej_hdr = ^ej_head[FLIT_W-1:PAYLOAD_W];
  assign rd_valid      = !ej_empty;
  assign rd_data       = ej_head[PAYLOAD_W-1:0];

  always_comb begin
    credit_cnt_d   = credit_cnt_q;
    inject_d       = inject_q;
    inject_valid_d = send;
    co_d           = ej_pop;
    read_d         = read_q;
    err_d          = err_q;
    if (send) inject_d = inj_head;
    // A credit arriving alongside a send leaves the count unchanged.
    if (ci && !send) begin
      if (credit_cnt_q == CW'(CREDITS)) err_d[ERR_CREDIT_OVF] = 1'b1;
      else credit_cnt_d = credit_cnt_q + CW'(1);
    end else if (!ci && send) begin
      credit_cnt_d = credit_cnt_q - CW'(1);
    end
    if (ej_pop) read_d = ej_head[PAYLOAD_W-1:0];
    if (ej_drop) err_d[ERR_EJ_OVF] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_q   <= CW'(CREDITS);
      inject_q       <= '0;
      inject_valid_q <= 1'b0;
      co_q           <= 1'b0;
      read_q         <= '0;
      err_q          <= '0;
    end else begin
      credit_cnt_q   <= credit_cnt_d;
      inject_q       <= inject_d;
      inject_valid_q <= inject_valid_d;
      co_q           <= co_d;
      read_q         <= read_d;
      err_q          <= err_d;
    end
  end

  assign inject       = inject_q;
  assign inject_valid = inject_valid_q;
  assign co           = co_q;
  assign read         = read_q;
  assign err          = err_q;

`ifdef NOC_NI_STATS_EN
  logic [15:0] stat_inj_q, stat_inj_d, stat_ej_q, stat_ej_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_inj_d   = stat_inj_q;
    stat_ej_d    = stat_ej_q;
    stat_stall_d = stat_stall_q;
    if (send && stat_inj_q != 16'hFFFF) stat_inj_d = stat_inj_q + 16'd1;
    if (eject_valid && !ej_drop && stat_ej_q != 16'hFFFF) stat_ej_d = stat_ej_q + 16'd1;
    if (!inj_empty && credit_cnt_q == '0 && stat_stall_q != 16'hFFFF) stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_inj_q   <= '0;
      stat_ej_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_inj_q   <= stat_inj_d;
      stat_ej_q    <= stat_ej_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_inj   = stat_inj_q;
  assign stat_ej    = stat_ej_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_noc_network_interface.sv
// tb/tb_noc_network_interface.sv - directed and randomized checks of the NI against a queue-based reference model.
module tb_noc_network_interface;

  localparam int ADDR_W    = 2;
  localparam int PAYLOAD_W = 16;
  localparam int FLIT_W    = 2 * ADDR_W + PAYLOAD_W;
  localparam int INJ_DEPTH = 4;
  localparam int EJ_DEPTH  = 4;
  localparam int CREDITS   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 pe_valid;
  logic                 pe_ready;
  logic [ADDR_W-1:0]    pe_dest_cluster;
  logic [ADDR_W-1:0]    pe_dest_local;
  logic [PAYLOAD_W-1:0] pe_data;
  logic [FLIT_W-1:0]    inject;
  logic                 inject_valid;
  logic                 ci;
  logic [FLIT_W-1:0]    eject;
  logic                 eject_valid;
  logic                 co;
  logic                 rd_valid;
  logic                 rd_en;
  logic [PAYLOAD_W-1:0] rd_data;
  logic [PAYLOAD_W-1:0] read;
  logic [1:0]           err;
`ifdef NOC_NI_STATS_EN
  logic [15:0]          stat_inj, stat_ej, stat_stall;
`endif

  always #5 clk = ~clk;

  noc_network_interface #(
    .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .INJ_DEPTH(INJ_DEPTH),
    .EJ_DEPTH(EJ_DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_dest_cluster(pe_dest_cluster), .pe_dest_local(pe_dest_local), .pe_data(pe_data),
    .inject(inject), .inject_valid(inject_valid), .ci(ci), .eject(eject),
    .eject_valid(eject_valid), .co(co), .rd_valid(rd_valid), .rd_en(rd_en),
    .rd_data(rd_data), .read(read), .err(err)
`ifdef NOC_NI_STATS_EN
    , .stat_inj(stat_inj), .stat_ej(stat_ej), .stat_stall(stat_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the NI should present after the most recent clock edge.
  int inj_m[$];
  int ej_m[$];
  int cred_m, err_m, read_m, co_m, inj_out_m, iv_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    inj_m.delete();
    ej_m.delete();
    cred_m = CREDITS; err_m = 0; read_m = 0; co_m = 0; inj_out_m = 0; iv_m = 0;
  endtask

  task automatic model_step();
    int  c;
    bit  send, acc, pop, drop;
    if (rst) begin
      model_reset();
      return;
    end
    send = (inj_m.size() > 0) && (cred_m > 0);
    acc  = pe_valid && (inj_m.size() < INJ_DEPTH);
    pop  = rd_en && (ej_m.size() > 0);
    drop = eject_valid && (ej_m.size() == EJ_DEPTH) && !pop;
    iv_m = send;
    if (send) inj_out_m = inj_m.pop_front();
    if (acc) inj_m.push_back(int'(pe_dest_cluster) * (1 << 18) + int'(pe_dest_local) * (1 << 16) + int'(pe_data));
    c = cred_m - int'(send) + int'(ci);
    if (c > CREDITS) begin
      c = CREDITS;
      err_m = err_m | 2;
    end
    cred_m = c;
    co_m = pop;
    if (pop) read_m = ej_m.pop_front();
    if (eject_valid) begin
      if (drop) err_m = err_m | 1;
      else ej_m.push_back(int'(eject) % 65536);
    end
  endtask

  task automatic check_all();
    check("pe_ready", pe_ready, inj_m.size() < INJ_DEPTH);
    check("inject_valid", inject_valid, iv_m);
    check("inject", inject, inj_out_m);
    check("co", co, co_m);
    check("rd_valid", rd_valid, ej_m.size() > 0);
    check("rd_data", rd_data, (ej_m.size() > 0) ? ej_m[0] : 0);
    check("read", read, read_m);
    check("err", err, err_m);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input int r, input int pv, input int dc, input int dl, input int d,
                      input int c, input int ev, input int e, input int re);
    rst             = (r != 0);
    pe_valid        = (pv != 0);
    pe_dest_cluster = dc[ADDR_W-1:0];
    pe_dest_local   = dl[ADDR_W-1:0];
    pe_data         = d[PAYLOAD_W-1:0];
    ci              = (c != 0);
    eject_valid     = (ev != 0);
    eject           = e[FLIT_W-1:0];
    rd_en           = (re != 0);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int sent;
  int r_rst, r_ci, r_ev, r_re;

  initial begin
    model_reset();
    do_reset();
    do_reset();
    check("reset_pe_ready", pe_ready, 1);
    check("reset_err", err, 0);

    // Single request: dest 2/1, payload BEEF.
    step(0, 1, 2, 1, 'hBEEF, 0, 0, 0, 0);
    check("single_not_yet", inject_valid, 0);
    idle(1);
    check("single_valid", inject_valid, 1);
    check("single_flit", inject, 20'h9BEEF);
    idle(1);
    check("single_one_cycle", inject_valid, 0);

    // Five back-to-back requests with four credits.
    do_reset();
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i % 4, (i + 1) % 4, 'h100 + i, 0, 0, 0, 0);
      sent += int'(inject_valid);
    end
    idle(1);
    sent += int'(inject_valid);
    check("b2b_four_sent", sent, 4);
    idle(2);
    check("b2b_fifth_held", inject_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("b2b_ci_edge", inject_valid, 0);
    idle(1);
    check("b2b_fifth_sent", inject_valid, 1);
    check("b2b_fifth_flit", inject, 20'h10104);

    // Drain credits, then fill the injection FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, 3, 3, i, 0, 0, 0, 0);
    check("fill_not_ready", pe_ready, 0);
    step(0, 1, 0, 0, 'hDEAD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("fill_still_full", pe_ready, 0);
    idle(1);
    check("fill_ready_again", pe_ready, 1);
    check("fill_sent_first", inject, 20'hF0004);

    // Single eject and pop.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 'h01234, 0);
    check("ej_rd_valid", rd_valid, 1);
    check("ej_rd_data", rd_data, 16'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("ej_read", read, 16'h1234);
    check("ej_co", co, 1);
    idle(1);
    check("ej_co_once", co, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("ej_empty_pop_co", co, 0);

    // Ejection overflow.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 'h30000 + 'h11 * (i + 1), 0);
    check("ovf_err", err, 2'b01);
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("ovf_order", read, 16'h11 * (i + 1));
      sent += int'(co);
    end
    check("ovf_co_count", sent, 4);

    // Credit overflow, then reset mid-stream.
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("cred_ovf_err", err, 2'b10);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, i, 0, 1, 'h0AAAA + i, 0);
    do_reset();
    check("rst_err", err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_inject", inject, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 399) == 0) ? 1 : 0;
      if (cred_m < CREDITS) r_ci = ($urandom_range(0, 3) == 0) ? 1 : 0;
      else r_ci = ($urandom_range(0, 60) == 0) ? 1 : 0;
      r_ev = ($urandom_range(0, 2) != 0) ? 1 : 0;
      r_re = (((i / 500) % 2) == 0) ? (($urandom_range(0, 3) == 0) ? 1 : 0)
                                    : (($urandom_range(0, 3) != 0) ? 1 : 0);
      step(r_rst, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 65535)), r_ci, r_ev, int'($urandom_range(0, 1048575)), r_re);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_network_interface.md
# noc_network_interface

Parametrised network interface between a processing element and the local (port 5) injection/ejection port of a cluster router.
- Packs PE requests into flits, buffers them in an injection FIFO, and releases them under credit-based flow control.
- Buffers ejected flits for the PE and returns one credit per flit consumed.
- Lets PEs stop handling router flow control directly; supports configurable flit width, buffer depths and credit count.

## Interface
- ADDR_W, 2, width of cluster and local address fields
- PAYLOAD_W, 16, flit payload width; FLIT_W = 2*ADDR_W + PAYLOAD_W
- INJ_DEPTH, 4, injection FIFO depth (power of two, ≥2)
- EJ_DEPTH, 4, ejection FIFO depth (power of two, ≥2)
- CREDITS, 4, router local-port input buffer depth; initial credit count (1..15)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- pe_valid  input  1  PE injection request
- pe_ready  output  1  NI can accept request
- pe_dest_cluster  input  ADDR_W  destination cluster
- pe_dest_local  input  ADDR_W  destination node in cluster
- pe_data  input  PAYLOAD_W  payload
- inject  output  FLIT_W  flit to router: {dest_cluster, dest_local, payload}
- inject_valid  output  1  one-cycle flit strobe to router
- ci  input  1  one-cycle credit return from router
- eject  input  FLIT_W  flit from router
- eject_valid  input  1  eject flit strobe
- co  output  1  one-cycle credit pulse to router
- rd_valid  output  1  ejection FIFO non-empty
- rd_en  input  1  PE pop request
- rd_data  output  PAYLOAD_W  payload at head of ejection FIFO (show-ahead)
- read  output  PAYLOAD_W  last popped payload, registered
- err  output  2  sticky: [0] eject overflow drop, [1] credit overflow

## Operation
- Injection accept: pe_valid && pe_ready pushes packed flit; pe_ready = !inj_full.
- Injection send:
  - Condition: inj FIFO non-empty && credit_cnt > 0.
  - Pops head into registered inject, asserts inject_valid for one cycle, decrements credit_cnt.
  - Sends at most one flit per cycle.
- Credit counter (width clog2(CREDITS+1)):
  - Send and ci in the same cycle: net unchanged.
  - ci while credit_cnt == CREDITS: counter saturates, err[1] set.
- Ejection:
  - eject_valid pushes flit into ej FIFO.
  - If full and no pop that cycle: flit dropped, err[0] set.
  - If full with simultaneous pop: push accepted.
- Pop: rd_en && rd_valid removes head, loads its payload into read, and co pulses high the following cycle. rd_en while empty is ignored.
- Reset state:
  - Empty FIFOs; credit_cnt = CREDITS.
  - Outputs: pe_ready=1, inject=0, inject_valid=0, co=0, rd_valid=0, rd_data=0, read=0, err=0.
- Reset mid-operation: buffered flits and in-flight credits are discarded. The router must be reset in the same cycle.

## Timing
- Accept-to-inject_valid: 1 cycle minimum, when FIFO empty and credits available.
- Throughput: one flit per cycle, sustained while credits ≥1.
- With CREDITS=1 and a 1-cycle router credit loop: one flit every 3 cycles.
- eject_valid to rd_valid: 1 cycle.
- rd_en pop to co pulse: 1 cycle, co registered. read updates on the same edge as the pop.
- No combinational path from ci, eject_valid or rd_en to any output except rd_data/rd_valid through FIFO state.

## Configuration
- NOC_NI_STATS_EN defined:
  - Adds outputs stat_inj, stat_ej and stat_stall, each 16 bits and saturating at 0xFFFF, reset to 0.
  - stat_inj counts injected flits.
  - stat_ej counts accepted ejected flits.
  - stat_stall counts cycles with inj FIFO non-empty and credit_cnt == 0.
- Not defined: ports and counters absent. Functional behaviour is identical.

## Structure
- noc_pkg holds:
  - ADDR_W and PAYLOAD_W defaults and flit field offsets.
  - Flit pack/unpack functions.
  - err bit index constants.
- Sub-module noc_sync_fifo (parameterised WIDTH, DEPTH; show-ahead; full/empty flags) is instantiated twice: injection and ejection.
- Credit counter, output registers and stats live in the top module.

## Test plan
- Reset, then single request (dest 2/1, data 0xBEEF): inject=0x9BEEF (ADDR_W=2) with inject_valid one cycle later; credit_cnt 4→3.
- Five back-to-back requests, no ci, CREDITS=4: four flits sent on consecutive cycles; fifth held until one ci pulse, then sent the cycle after.
- INJ_DEPTH=4 fill with credits 0: pe_ready falls after fourth accept, rises one cycle after first ci-enabled send.
- Eject 0x01234 then rd_en: rd_valid one cycle after eject, rd_data=0x1234, read=0x1234 after pop, co pulse the next cycle.
- Five ejects, no pops, EJ_DEPTH=4: fifth dropped, err=2'b01. Four pops return the first four payloads in order, giving four co pulses.
- ci with credit_cnt at 4: err[1] set, count stays 4. rst mid-stream clears FIFOs, err and the counter back to 4.
